// File: rtl/phase_gen.sv
// phase_gen: multi-channel square-wave phase generator.
// Each channel toggles its phase every act+1 cycles and emits one-cycle
// rise/fall strobes. Divisors are reloaded through shadow registers at the
// start of a period so no period is ever truncated. Channel 0 (CPU phase)
// can be halted low and single-stepped one full period at a time.
module phase_gen #(
    parameter int NCH   = 3,
    parameter int CNT_W = 8,
    // Channel i lives in bits [i*CNT_W +: CNT_W]: ch0 = 1, ch1 = 0, ch2 = 24.
    parameter logic [NCH*CNT_W-1:0] DEF_DIV = {8'd24, 8'd0, 8'd1}
) (
    input  logic                 CLOCK_50,
    input  logic                 res,
    input  logic [NCH*CNT_W-1:0] div_i,
    input  logic                 load,
    input  logic                 resync,
    input  logic                 halt_req,
    input  logic                 step,
    output logic [NCH-1:0]       phi,
    output logic [NCH-1:0]       rise_en,
    output logic [NCH-1:0]       fall_en,
    output logic                 halted
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTING = 2'd1,
        S_HALT    = 2'd2,
        S_STEP    = 2'd3
    } state_t;

    logic [NCH-1:0][CNT_W-1:0] r_cnt;
    logic [NCH-1:0][CNT_W-1:0] r_act;
    logic [NCH-1:0][CNT_W-1:0] r_sh;
    logic [NCH-1:0]            r_pend;
    logic [NCH-1:0]            r_phi;
    logic [NCH-1:0]            r_rise;
    logic [NCH-1:0]            r_fall;
    logic                      r_halted;
    state_t                    r_state;

    logic [NCH-1:0][CNT_W-1:0] w_div;
    logic [NCH-1:0]            w_tick;
    logic [NCH-1:0]            w_run;

    assign w_div = div_i;

    // Half-period terminal count per channel and channel-0 freeze qualifier.
    always_comb begin
        w_tick = '0;
        w_run  = '1;
        for (int i = 0; i < NCH; i++) begin
            w_tick[i] = (r_cnt[i] == r_act[i]);
        end
        // Channel 0 is frozen low in HALT, and also while HALTING with the
        // phase already low so no extra edge is produced on the way in.
        if (r_state == S_HALT) begin
            w_run[0] = 1'b0;
        end else if ((r_state == S_HALTING) && !r_phi[0]) begin
            w_run[0] = 1'b0;
        end else begin
            w_run[0] = 1'b1;
        end
    end

    // Per-channel counters, phases, strobes and divisor shadow/apply logic.
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            r_cnt  <= '0;
            r_phi  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_act  <= DEF_DIV;
            r_sh   <= DEF_DIV;
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (resync) begin
                    // Realign: everything restarts low; pending divisors
                    // (including one loaded this very cycle) take effect now.
                    r_cnt[i]  <= '0;
                    r_phi[i]  <= 1'b0;
                    r_rise[i] <= 1'b0;
                    r_fall[i] <= 1'b0;
                    if (load) begin
                        r_act[i] <= w_div[i];
                    end else if (r_pend[i]) begin
                        r_act[i] <= r_sh[i];
                    end else begin
                        r_act[i] <= r_act[i];
                    end
                    r_pend[i] <= 1'b0;
                end else if (!w_run[i]) begin
                    r_cnt[i]  <= '0;
                    r_phi[i]  <= 1'b0;
                    r_rise[i] <= 1'b0;
                    r_fall[i] <= 1'b0;
                end else if (w_tick[i]) begin
                    r_cnt[i]  <= '0;
                    r_phi[i]  <= ~r_phi[i];
                    r_rise[i] <= ~r_phi[i];
                    r_fall[i] <= r_phi[i];
                    // New divisor only at the start of a period (0->1 edge).
                    if (!r_phi[i] && r_pend[i]) begin
                        r_act[i]  <= r_sh[i];
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_cnt[i]  <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                    r_rise[i] <= 1'b0;
                    r_fall[i] <= 1'b0;
                end
                // Capture overrides any clear above; only the last load wins.
                if (load) begin
                    r_sh[i] <= w_div[i];
                    if (!resync) begin
                        r_pend[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Channel-0 halt / single-step controller with registered halted flag.
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_halted <= 1'b0;
                    if (halt_req) begin
                        r_state <= S_HALTING;
                    end
                end
                S_HALTING: begin
                    // Stop on the natural falling edge, or at once if low.
                    if (!r_phi[0]) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_tick[0] && !resync) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_halted <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end else if (step) begin
                        r_state  <= S_STEP;
                        r_halted <= 1'b0;
                    end else begin
                        r_halted <= 1'b1;
                    end
                end
                S_STEP: begin
                    // One full period; finish on its falling edge.
                    if (r_phi[0] && w_tick[0] && !resync) begin
                        r_state  <= halt_req ? S_HALT : S_RUN;
                        r_halted <= halt_req;
                    end else begin
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign phi     = r_phi;
    assign rise_en = r_rise;
    assign fall_en = r_fall;
    assign halted  = r_halted;

endmodule

// File: tb/tb_phase_gen.sv
// Directed self-checking bench for phase_gen (defaults: ch0 div 1,
// ch1 div 0, ch2 div 24). Edge numbers count posedges since reset release.
module tb_phase_gen;

    logic        clk;
    logic        res;
    logic [23:0] div_i;
    logic        load;
    logic        resync;
    logic        halt_req;
    logic        step;
    logic [2:0]  phi;
    logic [2:0]  rise_en;
    logic [2:0]  fall_en;
    logic        halted;

    int cyc;
    int n_chk;
    int n_pass;
    int at;
    int n_r0;
    int n_f0;
    int n_lo;

    phase_gen dut (
        .CLOCK_50 (clk),
        .res      (res),
        .div_i    (div_i),
        .load     (load),
        .resync   (resync),
        .halt_req (halt_req),
        .step     (step),
        .phi      (phi),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance until the selected strobe appears; at = edge number or -1.
    task automatic run_until(input int ch, input bit want_rise, input int budget, output int found);
        found = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (want_rise ? rise_en[ch] : fall_en[ch]) begin
                found = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        res = 1'b0; div_i = 24'd0; load = 1'b0; resync = 1'b0;
        halt_req = 1'b0; step = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_phi", {29'd0, phi}, 32'd0);
        check("rst_strb", {26'd0, rise_en, fall_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        res = 1'b1;
        cyc = 0;

        // Default divisors after release
        tick(); check("e1_phi", {29'd0, phi}, 32'd2); check("e1_rise", {29'd0, rise_en}, 32'd2);
        tick(); check("e2_phi", {29'd0, phi}, 32'd1); check("e2_rise", {29'd0, rise_en}, 32'd1);
                check("e2_fall", {29'd0, fall_en}, 32'd2);
        tick(); check("e3_phi", {29'd0, phi}, 32'd3); check("e3_fall", {29'd0, fall_en}, 32'd0);
        tick(); check("e4_phi", {29'd0, phi}, 32'd0); check("e4_fall", {29'd0, fall_en}, 32'd3);
        run_until(2, 1'b1, 40, at); check("ch2_first_rise", at, 32'd25);
        check("e25_phi", {29'd0, phi}, 32'd6);
        tick(); check("e26_fall", {29'd0, fall_en}, 32'd2);
        tick(); check("e27_fall", {29'd0, fall_en}, 32'd0);

        // Glitch-free reload of ch2 to 4 at cnt=10 of its high half
        repeat (8) tick();
        div_i = 24'h04_00_01; load = 1'b1;
        tick(); load = 1'b0;
        run_until(2, 1'b0, 40, at); check("reload_fall_old", at, 32'd50);
        run_until(2, 1'b1, 40, at); check("reload_rise_old", at, 32'd75);
        run_until(2, 1'b0, 40, at); check("reload_fall_new", at, 32'd80);
        run_until(2, 1'b1, 40, at); check("reload_rise_new", at, 32'd85);

        // Resync together with load: ch2 becomes div 1, aligned to ch0
        repeat (3) tick();
        div_i = 24'h01_00_01; load = 1'b1; resync = 1'b1;
        tick(); load = 1'b0; resync = 1'b0;
        check("rsync_phi", {29'd0, phi}, 32'd0);
        check("rsync_strb", {26'd0, rise_en, fall_en}, 32'd0);
        tick(); check("e90_phi", {29'd0, phi}, 32'd2);
        tick(); check("e91_rise", {29'd0, rise_en}, 32'd5); check("e91_phi", {29'd0, phi}, 32'd5);

        // Halt requested in the first high cycle of ch0
        halt_req = 1'b1;
        tick(); check("e92_halted", {31'd0, halted}, 32'd0);
        tick(); check("halt_phi", {29'd0, phi}, 32'd0);
                check("halt_fall", {29'd0, fall_en}, 32'd7);
                check("halt_flag", {31'd0, halted}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(); check("frozen_ch0", {30'd0, phi[0], rise_en[0]}, 32'd0);
            if (k == 1) check("ch2_runs", {31'd0, phi[2]}, 32'd1);
        end

        // Single step: one period of 4 cycles, second step pulse ignored
        step = 1'b1;
        n_r0 = 0; n_f0 = 0; n_lo = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rise_en[0]) n_r0++;
            if (fall_en[0]) n_f0++;
            if (!halted) n_lo++;
            step = (k == 1) ? 1'b1 : 1'b0;
        end
        check("step_rises", n_r0, 32'd1);
        check("step_falls", n_f0, 32'd1);
        check("step_len", n_lo, 32'd4);
        check("step_rehalt", {31'd0, halted}, 32'd1);

        // Release halt: halted drops next cycle, ch0 rises two later
        repeat (2) tick();
        halt_req = 1'b0;
        tick(); check("rel_halted", {31'd0, halted}, 32'd0); check("rel_phi0", {31'd0, phi[0]}, 32'd0);
        tick(); check("rel_phi0_b", {31'd0, phi[0]}, 32'd0);
        tick(); check("rel_rise", {29'd0, rise_en}, 32'd5); check("rel_phi", {29'd0, phi}, 32'd5);

        // Async reset in STEP with a load pending
        halt_req = 1'b1;
        tick(); tick(); check("halt2", {31'd0, halted}, 32'd1);
        step = 1'b1;
        tick(); step = 1'b0; div_i = 24'h07_07_07; load = 1'b1;
        tick(); load = 1'b0;
        tick(); check("pre_rst_phi1", {31'd0, phi[1]}, 32'd1);
        #2;
        res = 1'b0; halt_req = 1'b0;
        #1;
        check("async_rst", {25'd0, phi, rise_en, fall_en, halted}, 32'd0);
        @(posedge clk);
        #1;
        res = 1'b1;
        cyc = 0;
        tick(); check("r2_e1_phi", {29'd0, phi}, 32'd2);
        tick(); check("r2_e2_phi", {29'd0, phi}, 32'd1);
        run_until(2, 1'b1, 40, at); check("r2_ch2_rise", at, 32'd25);
        run_until(2, 1'b0, 40, at); check("r2_ch2_fall", at, 32'd50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
